// File: rtl/video_pkg.sv
// Shared definitions for the video RAM port arbiter: window defaults,
// arbiter state encoding and the buffered CPU write entry.
package video_pkg;

   localparam logic [15:0] VRAM_BASE_DEFAULT = 16'h8000;
   localparam logic [15:0] VRAM_TOP_DEFAULT  = 16'hF530;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_READ  = 2'd1,
      ST_WRITE = 2'd2
   } arb_state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [7:0]  data;
   } fifo_entry_t;

   // Both window edges are inclusive.
   function automatic logic addr_in_window(input logic [15:0] addr,
                                           input logic [15:0] lo,
                                           input logic [15:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/video_write_fifo.sv
// CPU write buffer: small circular FIFO with a combinational head so the
// arbiter can pop and issue the entry in the same cycle.
module video_write_fifo
   import video_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_push,
   input  fifo_entry_t i_entry,
   input  logic        i_pop,
   output fifo_entry_t o_head,
   output logic [4:0]  o_level,
   output logic        o_full,
   output logic        o_empty
);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   fifo_entry_t      r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [4:0]       r_level;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_level == 5'(DEPTH));
   assign o_empty   = (r_level == 5'd0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];
   assign o_level   = r_level;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= 5'd0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
         case ({w_do_push, w_do_pop})
            2'b10:   r_level <= r_level + 5'd1;
            2'b01:   r_level <= r_level - 5'd1;
            default: r_level <= r_level;
         endcase
      end
   end

   // Storage carries no reset; the pointers define which slots are live.
   always_ff @(posedge clk) begin
      if (w_do_push) r_mem[r_wr_ptr] <= i_entry;
   end

endmodule

// File: rtl/video_port_arbiter.sv
// Video RAM port arbiter: display reads have strict priority; in-window CPU
// writes are buffered and drained into cycles the display does not use.
module video_port_arbiter
   import video_pkg::*;
#(
   parameter int          FIFO_DEPTH = 4,
   parameter logic [15:0] VRAM_BASE  = VRAM_BASE_DEFAULT,
   parameter logic [15:0] VRAM_TOP   = VRAM_TOP_DEFAULT
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] cAddress,
   input  logic [7:0]  cData,
   input  logic        cWrite,
   output logic        cStall,
   input  logic        dReq,
   input  logic [15:0] dAddress,
   output logic [7:0]  dData,
   output logic        dValid,
   output logic [15:0] vAddress,
   output logic [7:0]  vData,
   output logic        vWrite,
   output logic        vRead,
   input  logic [7:0]  vQ,
   output logic [4:0]  fifoLevel
);
   arb_state_t  r_state;
   arb_state_t  w_state_next;
   fifo_entry_t w_head;
   fifo_entry_t w_push_entry;
   logic        w_in_window;
   logic        w_push;
   logic        w_pop;
   logic        w_full;
   logic        w_empty;
   logic [15:0] r_vaddr;
   logic [7:0]  r_vdata;
   logic        r_rd_pending;
   logic        r_dvalid;
   logic [7:0]  r_ddata;

   assign w_in_window  = addr_in_window(cAddress, VRAM_BASE, VRAM_TOP);
   assign w_push       = cWrite && w_in_window && !w_full;
   assign w_push_entry = '{addr: cAddress, data: cData};

   video_write_fifo #(
      .DEPTH   (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_entry (w_push_entry),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_level (fifoLevel),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Stall depends only on the registered level, never on the address.
   assign cStall = w_full;

   always_ff @(posedge clk) begin
      if (reset) r_state <= ST_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = ST_IDLE;
      w_pop        = 1'b0;
      if (dReq) begin
         w_state_next = ST_READ;
      end else if (!w_empty) begin
         w_state_next = ST_WRITE;
         w_pop        = 1'b1;
      end
   end

   assign vRead    = (r_state == ST_READ);
   assign vWrite   = (r_state == ST_WRITE);
   assign vAddress = r_vaddr;
   assign vData    = r_vdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_vaddr <= 16'h0000;
         r_vdata <= 8'h00;
      end else if (w_state_next == ST_READ) begin
         r_vaddr <= dAddress;
      end else if (w_state_next == ST_WRITE) begin
         r_vaddr <= w_head.addr;
         r_vdata <= w_head.data;
      end
   end

   // vQ arrives the cycle after vRead and is registered once more for dData.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_rd_pending <= 1'b0;
         r_dvalid     <= 1'b0;
         r_ddata      <= 8'h00;
      end else begin
         r_rd_pending <= (r_state == ST_READ);
         r_dvalid     <= r_rd_pending;
         if (r_rd_pending) r_ddata <= vQ;
      end
   end

   assign dValid = r_dvalid;
   assign dData  = r_ddata;

endmodule

// File: tb/tb_video_port_arbiter.sv
// Randomized and directed bench for video_port_arbiter against a queue-based
// transaction model of the arbitration and read-latency rules.
module tb_video_port_arbiter;
   localparam int DEPTH = 4;

   typedef struct {
      logic [15:0] addr;
      logic [7:0]  data;
   } ent_t;

   typedef struct {
      int         cyc;
      logic [7:0] data;
   } rd_t;

   logic        clk;
   logic        reset;
   logic [15:0] cAddress;
   logic [7:0]  cData;
   logic        cWrite;
   logic        cStall;
   logic        dReq;
   logic [15:0] dAddress;
   logic [7:0]  dData;
   logic        dValid;
   logic [15:0] vAddress;
   logic [7:0]  vData;
   logic        vWrite;
   logic        vRead;
   logic [7:0]  vQ;
   logic [4:0]  fifoLevel;

   video_port_arbiter #(
      .FIFO_DEPTH (DEPTH),
      .VRAM_BASE  (16'h8000),
      .VRAM_TOP   (16'hF530)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .cAddress  (cAddress),
      .cData     (cData),
      .cWrite    (cWrite),
      .cStall    (cStall),
      .dReq      (dReq),
      .dAddress  (dAddress),
      .dData     (dData),
      .dValid    (dValid),
      .vAddress  (vAddress),
      .vData     (vData),
      .vWrite    (vWrite),
      .vRead     (vRead),
      .vQ        (vQ),
      .fifoLevel (fifoLevel)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] vram_f(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hCA;
   endfunction

   // VRAM model: data for the read address one cycle after vRead, noise otherwise.
   always @(posedge clk) vQ <= vRead ? vram_f(vAddress) : 8'($urandom);

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
      end
   endtask

   // Model state
   ent_t        mq[$];
   rd_t         rd_due[$];
   int          exp_op;       // 0 idle, 1 read, 2 write
   logic [15:0] exp_vaddr;
   logic [7:0]  exp_vdata;
   bit          after_rst;
   bit          last_accepted;
   int          n_vwr;
   int          n_dv;
   int          max_level;
   bit          saw_stall;
   logic [7:0]  last_ddata;

   task automatic step(input logic rst, input logic wr, input logic [15:0] a,
                       input logic [7:0] d, input logic rq, input logic [15:0] da);
      bit   stall;
      bit   exp_dv;
      ent_t e;
      reset = rst; cWrite = wr; cAddress = a; cData = d; dReq = rq; dAddress = da;
      @(negedge clk);
      check_eq("cStall", 32'(cStall), 32'(mq.size() == DEPTH));
      check_eq("fifoLevel", 32'(fifoLevel), 32'(mq.size()));
      check_eq("vRead", 32'(vRead), 32'(exp_op == 1));
      check_eq("vWrite", 32'(vWrite), 32'(exp_op == 2));
      check_eq("overlap", 32'(vRead & vWrite), 32'd0);
      check_eq("vAddress", 32'(vAddress), 32'(exp_vaddr));
      if (exp_op != 1) check_eq("vData", 32'(vData), 32'(exp_vdata));
      exp_dv = (rd_due.size() > 0) && (rd_due[0].cyc == cyc);
      check_eq("dValid", 32'(dValid), 32'(exp_dv));
      if (exp_dv) begin
         check_eq("dData", 32'(dData), 32'(rd_due[0].data));
         void'(rd_due.pop_front());
      end
      if (after_rst) check_eq("dData_rst", 32'(dData), 32'd0);
      if (vWrite) begin
         n_vwr++;
         $display("cycle %0d vram write addr=%04h data=%02h", cyc, vAddress, vData);
      end
      if (dValid) begin
         n_dv++;
         last_ddata = dData;
         $display("cycle %0d display read data=%02h", cyc, dData);
      end
      if (int'(fifoLevel) > max_level) max_level = int'(fifoLevel);
      if (cStall) saw_stall = 1'b1;
      // Rules applied at this edge
      last_accepted = 1'b0;
      if (rst) begin
         mq.delete();
         rd_due.delete();
         exp_op    = 0;
         exp_vaddr = 16'h0000;
         exp_vdata = 8'h00;
      end else begin
         stall = (mq.size() == DEPTH);
         if (rq) begin
            exp_op    = 1;
            exp_vaddr = da;
            rd_due.push_back('{cyc: cyc + 3, data: vram_f(da)});
         end else if (mq.size() > 0) begin
            e         = mq.pop_front();
            exp_op    = 2;
            exp_vaddr = e.addr;
            exp_vdata = e.data;
         end else begin
            exp_op = 0;
         end
         if (wr && a >= 16'h8000 && a <= 16'hF530 && !stall) begin
            mq.push_back('{addr: a, data: d});
            last_accepted = 1'b1;
         end
      end
      after_rst = rst;
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
   endtask

   function automatic logic [15:0] rand_addr();
      case ($urandom_range(0, 5))
         0:       return 16'h7FFF;
         1:       return 16'h8000;
         2:       return 16'hF530;
         3:       return 16'hF531;
         4:       return 16'($urandom);
         default: return 16'($urandom_range(16'h8000, 16'hF530));
      endcase
   endfunction

   initial begin
      int          n0;
      int          d0;
      logic        w;
      logic        rq;
      logic        rst;
      logic [15:0] a;
      logic [7:0]  d;
      bit          hold;

      reset = 1'b1; cWrite = 1'b0; cAddress = '0; cData = '0; dReq = 1'b0; dAddress = '0;
      exp_op = 0; exp_vaddr = '0; exp_vdata = '0; after_rst = 1'b1;
      n_vwr = 0; n_dv = 0; max_level = 0; saw_stall = 1'b0; last_ddata = '0;
      repeat (2) @(posedge clk);
      #1;
      // Inputs during reset are ignored
      step(1'b1, 1'b1, 16'h9000, 8'h77, 1'b1, 16'h9100);
      step(1'b1, 1'b1, 16'h9001, 8'h78, 1'b0, 16'h0);
      idle(2);

      // Window edges
      n0 = n_vwr;
      step(1'b0, 1'b1, 16'h7FFF, 8'h11, 1'b0, 16'h0);
      step(1'b0, 1'b1, 16'h8000, 8'h22, 1'b0, 16'h0);
      step(1'b0, 1'b1, 16'hF530, 8'h33, 1'b0, 16'h0);
      step(1'b0, 1'b1, 16'hF531, 8'h44, 1'b0, 16'h0);
      idle(4);
      check_eq("window_writes", 32'(n_vwr - n0), 32'd2);

      // Read latency
      d0 = n_dv;
      step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h9000);
      idle(5);
      check_eq("lat_count", 32'(n_dv - d0), 32'd1);
      check_eq("lat_data", 32'(last_ddata), 32'h5A);

      // Fill with display holding the port
      n0 = n_vwr; saw_stall = 1'b0; max_level = 0;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 16'h9000 + 16'(i), 8'hA0 + 8'(i), 1'b1, 16'h1234);
      check_eq("fill_level", 32'(fifoLevel), 32'd4);
      step(1'b0, 1'b1, 16'h9004, 8'hA4, 1'b1, 16'h1234);
      check_eq("fill_stall", 32'(cStall), 32'd1);
      step(1'b0, 1'b1, 16'h9004, 8'hA4, 1'b0, 16'h0);
      check_eq("drop_level", 32'(fifoLevel), 32'd3);
      step(1'b0, 1'b1, 16'h9004, 8'hA4, 1'b0, 16'h0);
      check_eq("held_accept_level", 32'(fifoLevel), 32'd3);
      check_eq("held_accept_stall", 32'(cStall), 32'd0);
      idle(6);
      check_eq("fill_writes", 32'(n_vwr - n0), 32'd5);
      check_eq("fill_max_level", 32'(max_level), 32'd4);

      // Contention: two buffered writes, then three display requests
      step(1'b0, 1'b1, 16'hA000, 8'h01, 1'b1, 16'h2000);
      step(1'b0, 1'b1, 16'hA001, 8'h02, 1'b1, 16'h2001);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h3000 + 16'(i));
      idle(6);

      // Reset mid-operation
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hB000 + 16'(i), 8'h50 + 8'(i), 1'b1, 16'h4000);
      step(1'b0, 1'b0, 16'h0, 8'h0, 1'b1, 16'h4444);
      step(1'b1, 1'b0, 16'h0, 8'h0, 1'b0, 16'h0);
      n0 = n_vwr; d0 = n_dv;
      idle(6);
      check_eq("rst_no_write", 32'(n_vwr - n0), 32'd0);
      check_eq("rst_no_valid", 32'(n_dv - d0), 32'd0);
      check_eq("rst_level", 32'(fifoLevel), 32'd0);

      // Concurrent push and pop at level 2
      step(1'b0, 1'b1, 16'hC000, 8'h90, 1'b1, 16'h5000);
      step(1'b0, 1'b1, 16'hC001, 8'h91, 1'b1, 16'h5001);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 16'hC002 + 16'(i), 8'h92 + 8'(i), 1'b0, 16'h0);
      check_eq("pushpop_level", 32'(fifoLevel), 32'd2);
      idle(4);

      // Random traffic; the CPU holds its request while stalled
      hold = 1'b0; w = 1'b0; a = '0; d = '0;
      for (int i = 0; i < 500; i++) begin
         if (!hold) begin
            w = 1'($urandom_range(0, 1));
            a = rand_addr();
            d = 8'($urandom);
         end
         rq  = ($urandom_range(0, 9) < 4);
         rst = ($urandom_range(0, 149) == 0);
         step(rst, w, a, d, rq, 16'($urandom));
         hold = w && a >= 16'h8000 && a <= 16'hF530 && !last_accepted && !rst;
      end
      idle(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/video_port_arbiter.md
VIDEO_PORT_ARBITER -- requirements
Module: video_port_arbiter

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, CPU write buffer entries; power of two, 2..16.
REQ-002 Parameter: VRAM_BASE, 16'h8000, lowest CPU address mapped to video RAM.
REQ-003 Parameter: VRAM_TOP, 16'hF530, highest CPU address mapped to video RAM (inclusive).
REQ-004 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-005 Port: reset  in  1  synchronous, active-high reset.
REQ-006 Port: cAddress  in  16  CPU write address.
REQ-007 Port: cData  in  8  CPU write data.
REQ-008 Port: cWrite  in  1  CPU write strobe, one request per high cycle.
REQ-009 Port: cStall  out  1  high when FIFO full; CPU holds cWrite/cAddress/cData until low.
REQ-010 Port: dReq  in  1  display scanout read request.
REQ-011 Port: dAddress  in  16  display read address.
REQ-012 Port: dData  out  8  display read data.
REQ-013 Port: dValid  out  1  one-cycle qualifier for dData.
REQ-014 Port: vAddress  out  16  video RAM address.
REQ-015 Port: vData  out  8  video RAM write data.
REQ-016 Port: vWrite  out  1  video RAM write enable.
REQ-017 Port: vRead  out  1  video RAM read enable.
REQ-018 Port: vQ  in  8  video RAM read data, valid the cycle after vRead.
REQ-019 Port: fifoLevel  out  5  current number of buffered CPU writes.

Function
REQ-020 A CPU write is in-window when VRAM_BASE <= cAddress <= VRAM_TOP (unsigned compare); boundary addresses are in-window.
REQ-021 cWrite with out-of-window address is ignored: no push, no stall, no VRAM access.
REQ-022 cStall = (fifoLevel == FIFO_DEPTH), combinational from registered level; independent of cAddress.
REQ-023 In-window cWrite with cStall low pushes {cAddress,cData} at the clock edge; with cStall high it is not accepted.
REQ-024 Simultaneous push and pop leaves fifoLevel unchanged; order is strictly FIFO.
REQ-025 Arbiter states: IDLE, READ, WRITE; state register drives vRead/vWrite/vAddress/vData (all registered).
REQ-026 Next state each cycle: dReq -> READ (vAddress=dAddress); else fifoLevel>0 -> WRITE (pop head, vAddress/vData=head); else IDLE.
REQ-027 Display has strict priority; no write ever delays a read.
REQ-028 vRead and vWrite never high in the same cycle; in IDLE both low, vAddress/vData hold last value.
REQ-029 Read latency fixed: dReq high in cycle k -> vRead high in k+1 -> vQ sampled end of k+2 -> dValid high, dData=vQ in cycle k+3.
REQ-030 Back-to-back dReq sustains one read per cycle; dValid pulses once per accepted dReq, in order.
REQ-031 A pop and a push of the same entry slot in one cycle is legal only when level>0; an entry pushed in cycle k is writable no earlier than cycle k+2.
REQ-032 Read-after-buffered-write to same address is not forwarded; display may see stale data (accepted behaviour).

Reset
REQ-033 reset high at an edge: state IDLE, FIFO empty, fifoLevel=0, cStall=0, vRead=vWrite=0, vAddress=16'h0000, vData=8'h00, dValid=0, dData=8'h00.
REQ-034 Reads and buffered writes in flight at reset are discarded; no dValid, no vWrite issued for them afterwards.
REQ-035 Inputs during reset cycles are ignored.

Structure
REQ-036 Shared package video_pkg holds VRAM_BASE/VRAM_TOP defaults, the arbiter state enum, and the FIFO entry type {addr[15:0],data[7:0]}.
REQ-037 FIFO implemented as one sub-module video_write_fifo (push/pop/level/full/empty, head output); arbiter, window decode and read pipeline stay in video_port_arbiter.

Verification
REQ-038 Window edges: cWrite at 16'h7FFF, 16'h8000, 16'hF530, 16'hF531 with data 11..44 -> exactly two vWrite cycles, (8000,22) then (F530,33).
REQ-039 Fill: 5 in-window writes back-to-back with dReq held high -> fifoLevel reaches 4, cStall high on 5th, held write accepted one cycle after dReq drops; 5 vWrite in order.
REQ-040 Read latency: dReq at cycle 10, dAddress=9000, VRAM model returns 5A -> vRead cycle 11, dValid with dData=5A cycle 13 only.
REQ-041 Contention: FIFO holding 2 writes, dReq pulses cycles 20-22 -> reads at 21-23, writes at 24-25, vRead/vWrite never overlap.
REQ-042 Reset mid-operation: reset in cycle after dReq with 3 writes buffered -> no dValid, no vWrite afterwards, fifoLevel=0, all outputs at reset values.
REQ-043 Simultaneous push/pop at level 2 for 10 cycles -> fifoLevel stays 2, write order matches push order.
